// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one registered radix-4 Booth 8x8 signed multiplier
// among NREQ requesters. Define MULT_STATS_EN to add the done_cnt handshake counter.
module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [15:0]       rsp_prod,
    output logic              busy
`ifdef MULT_STATS_EN
    ,
    output logic [15:0]       done_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [7:0]      op_a_reg;
    logic [7:0]      op_b_reg;
    logic [ID_W-1:0] op_id_reg;
    logic            rsp_valid_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic [15:0]     rsp_prod_reg;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   scan_idx;
    logic [7:0]      grant_a;
    logic [7:0]      grant_b;

    // Scan from rr_ptr+1 upward with wrap; iterating farthest-first lets the
    // nearest valid requester overwrite and win.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NREQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NREQ);
            end
            if (req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_a = req_a[8*i +: 8];
                grant_b = req_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Radix-4 Booth: four digits in {-2..2} recoded from overlapping triplets
    // of the multiplier, each scaling the sign-extended multiplicand.
    logic [8:0]  b_ext;
    logic [15:0] a_ext;
    logic [15:0] pp [4];
    logic [15:0] mult_prod;

    assign b_ext = {op_b_reg, 1'b0};
    assign a_ext = {{8{op_a_reg[7]}}, op_a_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_booth
            logic [15:0] digit_val;
            always_comb begin
                case (b_ext[2*gi+2 -: 3])
                    3'b001, 3'b010: digit_val = a_ext;
                    3'b011:         digit_val = a_ext << 1;
                    3'b100:         digit_val = -(a_ext << 1);
                    3'b101, 3'b110: digit_val = -a_ext;
                    default:        digit_val = '0;
                endcase
            end
            assign pp[gi] = digit_val << (2*gi);
        end
    endgenerate

    assign mult_prod = pp[0] + pp[1] + pp[2] + pp[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= ID_W'(NREQ-1);
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_id_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_prod_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        op_a_reg   <= grant_a;
                        op_b_reg   <= grant_b;
                        op_id_reg  <= grant_id;
                        rr_ptr_reg <= grant_id;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    rsp_prod_reg  <= mult_prod;
                    rsp_id_reg    <= op_id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign busy      = (state_reg != IDLE);

`ifdef MULT_STATS_EN
    logic [15:0] done_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_reg <= '0;
        end else if (rsp_valid_reg && rsp_ready) begin
            done_cnt_reg <= done_cnt_reg + 16'd1;
        end
    end

    assign done_cnt = done_cnt_reg;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: products queued at grant, compared at the
// response handshake; scenario tasks check timing, arbitration and reset.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       rsp_prod;
    logic              busy;
`ifdef MULT_STATS_EN
    logic [15:0]       done_cnt;
`endif

    mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
`ifdef MULT_STATS_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int hs_cnt    = 0;
    logic [17:0] sb_q[$];

    // Scoreboard monitor: push expected {id, product} on grant, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            hs_cnt = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [15:0] p;
                    p = $signed(req_a[8*i +: 8]) * $signed(req_b[8*i +: 8]);
                    sb_q.push_back({2'(i), p});
                    $display("grant  id=%0d a=%h b=%h expect=%h", i, req_a[8*i +: 8], req_b[8*i +: 8], p);
                end
            end
            if (rsp_valid && rsp_ready) begin
                logic [17:0] exp_v;
                hs_cnt++;
                check_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got id=%0d prod=%h, required no response", rsp_id, rsp_prod);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({rsp_id, rsp_prod} !== exp_v) begin
                        $display("FAIL sb_rsp: got id=%0d prod=%h, required id=%0d prod=%h",
                                 rsp_id, rsp_prod, exp_v[17:16], exp_v[15:0]);
                    end else begin
                        pass_cnt++;
                        $display("rsp    id=%0d prod=%h ok", rsp_id, rsp_prod);
                    end
                end
            end
        end
    end

    task automatic drive_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b required 0000", req_ready); else pass_cnt++;
        check_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); else pass_cnt++;
        check_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d required 0", rsp_id); else pass_cnt++;
        check_cnt++; if (rsp_prod !== 16'h0000) $display("FAIL reset_rsp_prod: got %h required 0000", rsp_prod); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        drive_op(0, 8'hFD, 8'h05);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        check_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b required 0001", req_ready); else pass_cnt++;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_t1_valid: got %b required 0", rsp_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("FAIL single_t1_busy: got %b required 1", busy); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_t2_valid: got %b required 1", rsp_valid); else pass_cnt++;
        check_cnt++; if (rsp_prod !== 16'hFFF1) $display("FAIL single_prod: got %h required fff1", rsp_prod); else pass_cnt++;
        check_cnt++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d required 0", rsp_id); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL single_t3_idle: got busy=%b valid=%b required 0 0", busy, rsp_valid); else pass_cnt++;
    endtask

    task automatic test_corners;
        logic [7:0]  a_tab [3] = '{8'h80, 8'h7F, 8'h00};
        logic [7:0]  b_tab [3] = '{8'h80, 8'h80, 8'hAB};
        logic [15:0] p_tab [3] = '{16'h4000, 16'hC080, 16'h0000};
        bit ok;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            drive_op(2, a_tab[t], b_tab[t]);
            req_valid = 4'b0100; rsp_ready = 1'b1;
            wait_grant(2, ok);
            check_cnt++; if (!ok) $display("FAIL corner_grant%0d: got no grant required grant to 2", t); else pass_cnt++;
            @(posedge clk); #1 req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL corner_valid%0d: got %b required 1", t, rsp_valid); else pass_cnt++;
            check_cnt++; if (rsp_prod !== p_tab[t]) $display("FAIL corner_prod%0d: got %h required %h", t, rsp_prod, p_tab[t]); else pass_cnt++;
            check_cnt++; if (rsp_id !== 2'd2) $display("FAIL corner_id%0d: got %0d required 2", t, rsp_id); else pass_cnt++;
        end
    endtask

    task automatic test_round_robin;
        int gid [6];
        int gcyc [6];
        int n = 0;
        @(posedge clk); #1 rst = 1'b1; req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) drive_op(i, 8'($urandom), 8'($urandom));
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            check_cnt++; if (!$onehot0(req_ready)) $display("FAIL rr_onehot: got %b required at most one bit", req_ready); else pass_cnt++;
            if (|req_ready) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid[n] = i;
                gcyc[n] = cyc;
                n++;
            end
        end
        check_cnt++;
        if (n != 6) begin
            $display("FAIL rr_count: got %0d grants required 6", n);
        end else begin
            pass_cnt++;
            for (int k = 0; k < 6; k++) begin
                check_cnt++; if (gid[k] != k % 4) $display("FAIL rr_order%0d: got %0d required %0d", k, gid[k], k % 4); else pass_cnt++;
                if (k > 0) begin
                    check_cnt++;
                    if (gcyc[k] - gcyc[k-1] != 3) $display("FAIL rr_spacing%0d: got %0d required 3", k, gcyc[k] - gcyc[k-1]); else pass_cnt++;
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_op(1, 8'h12, 8'hF3);
        req_valid = 4'b0010;
        wait_grant(1, ok);
        check_cnt++; if (!ok) $display("FAIL bp_grant: got no grant required grant to 1"); else pass_cnt++;
        @(posedge clk); #1 req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b required 1", c, rsp_valid); else pass_cnt++;
            check_cnt++; if (rsp_prod !== 16'hFF16) $display("FAIL bp_prod%0d: got %h required ff16", c, rsp_prod); else pass_cnt++;
            check_cnt++; if (rsp_id !== 2'd1) $display("FAIL bp_id%0d: got %0d required 1", c, rsp_id); else pass_cnt++;
            check_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b required 0000", c, req_ready); else pass_cnt++;
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_hs_valid: got %b required 1", rsp_valid); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle: got valid=%b busy=%b required 0 0", rsp_valid, busy); else pass_cnt++;
        check_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_next_grant: got %b required 0100", req_ready); else pass_cnt++;
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_hold;
        bit ok;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_op(2, 8'h80, 8'h80);
        req_valid = 4'b0100;
        wait_grant(2, ok);
        check_cnt++; if (!ok) $display("FAIL rh_grant: got no grant required grant to 2"); else pass_cnt++;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b1 || rsp_prod !== 16'h4000) $display("FAIL rh_hold: got valid=%b prod=%h required 1 4000", rsp_valid, rsp_prod); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
        @(negedge clk);
        check_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rh_valid: got %b required 0", rsp_valid); else pass_cnt++;
        check_cnt++; if (rsp_prod !== 16'h0000) $display("FAIL rh_prod: got %h required 0000", rsp_prod); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rh_busy: got %b required 0", busy); else pass_cnt++;
        check_cnt++; if (req_ready !== 4'b0001) $display("FAIL rh_first_grant: got %b required 0001", req_ready); else pass_cnt++;
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_corners;
        test_round_robin;
        test_backpressure;
        test_reset_hold;
        @(negedge clk);
        check_cnt++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending required 0", sb_q.size()); else pass_cnt++;
`ifdef MULT_STATS_EN
        check_cnt++; if (done_cnt !== 16'(hs_cnt)) $display("FAIL done_cnt: got %0d required %0d", done_cnt, hs_cnt); else pass_cnt++;
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
